// File: rtl/cpu_instruction_queue.sv
// Fetch-to-decode instruction queue with registered backpressure and branch delay-slot filtering.
// Optional INSTQ_ALIGN_CHECK_EN stores a misaligned-address flag per entry and drives out_adel.
module cpu_instruction_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in_address,
    input  logic [31:0] in_instruction,
    input  logic        in_valid,
    output logic        in_full,
    output logic [31:0] out_address,
    output logic [31:0] out_instruction,
    output logic        out_adel,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        branch_valid,
    input  logic [31:0] branch_inst_addr,
    input  logic [31:0] branch_address
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] PASS        = 2'd0;
    localparam logic [1:0] WAIT_SLOT   = 2'd1;
    localparam logic [1:0] WAIT_TARGET = 2'd2;

    logic [31:0]   mem_addr [DEPTH];
    logic [31:0]   mem_inst [DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic [1:0]    fstate;
    logic [31:0]   slot_addr, tgt_addr;

    logic          pop, push, room, accept, kept;
    logic [PW-1:0] kept_idx, idx;
    logic [31:0]   new_slot, eff_slot, eff_tgt;
    logic [1:0]    eff_state, fstate_next;
    logic [PW-1:0] base_head, base_tail;
    logic [CW-1:0] base_count, count_next;

    assign out_valid       = (count != '0);
    assign pop             = out_valid && out_ready;
    assign out_address     = mem_addr[head];
    assign out_instruction = mem_inst[head];
    assign new_slot        = branch_inst_addr + 32'd4;

    // First surviving entry (after this cycle's pop) that matches the delay slot.
    always_comb begin
        kept     = 1'b0;
        kept_idx = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (!kept && (CW'(i) < count) && !(i == 0 && pop) && mem_addr[idx] == new_slot) begin
                kept     = 1'b1;
                kept_idx = idx;
            end
        end
    end

    // A branch retargets the filter before the incoming word is judged.
    always_comb begin
        if (branch_valid) begin
            eff_state  = kept ? WAIT_TARGET : WAIT_SLOT;
            eff_slot   = new_slot;
            eff_tgt    = branch_address;
            base_head  = '0;
            base_tail  = kept ? PW'(1) : '0;
            base_count = kept ? CW'(1) : '0;
            room       = 1'b1;
        end else begin
            eff_state  = fstate;
            eff_slot   = slot_addr;
            eff_tgt    = tgt_addr;
            base_head  = head + PW'(pop);
            base_tail  = tail;
            base_count = count - CW'(pop);
            room       = (count < CW'(DEPTH));
        end
        case (eff_state)
            WAIT_SLOT:   accept = (in_address == eff_slot);
            WAIT_TARGET: accept = (in_address == eff_tgt);
            default:     accept = 1'b1;
        endcase
        push        = in_valid && room && accept;
        fstate_next = eff_state;
        if (push) begin
            if (eff_state == WAIT_SLOT)        fstate_next = WAIT_TARGET;
            else if (eff_state == WAIT_TARGET) fstate_next = PASS;
        end
        count_next = base_count + CW'(push);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            fstate    <= PASS;
            slot_addr <= '0;
            tgt_addr  <= '0;
            in_full   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_addr[i] <= '0;
                mem_inst[i] <= '0;
            end
        end else begin
            head    <= base_head;
            tail    <= base_tail + PW'(push);
            count   <= count_next;
            fstate  <= fstate_next;
            in_full <= (count_next >= CW'(DEPTH - 1));
            if (branch_valid) begin
                slot_addr <= new_slot;
                tgt_addr  <= branch_address;
                if (kept) begin
                    mem_addr[0] <= mem_addr[kept_idx];
                    mem_inst[0] <= mem_inst[kept_idx];
                end
            end
            // Kept slot lands in entry 0 and the push in entry 1, so they never collide.
            if (push) begin
                mem_addr[base_tail] <= in_address;
                mem_inst[base_tail] <= in_instruction;
            end
        end
    end

`ifdef INSTQ_ALIGN_CHECK_EN
    logic mem_adel [DEPTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_adel[i] <= 1'b0;
        end else begin
            if (branch_valid && kept) mem_adel[0] <= mem_adel[kept_idx];
            if (push) mem_adel[base_tail] <= (in_address[1:0] != 2'b00);
        end
    end

    assign out_adel = mem_adel[head];
`else
    assign out_adel = 1'b0;
`endif
endmodule

// File: tb/tb_cpu_instruction_queue.sv
// Directed table-driven bench for cpu_instruction_queue (DEPTH=4) plus a hand-written async reset sequence.
module tb_cpu_instruction_queue;
    localparam logic [31:0] IMASK = 32'h5a5a_0f0f;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] in_address = '0, in_instruction = '0;
    logic        in_valid = 1'b0, in_full;
    logic [31:0] out_address, out_instruction;
    logic        out_adel, out_valid;
    logic        out_ready = 1'b0, branch_valid = 1'b0;
    logic [31:0] branch_inst_addr = '0, branch_address = '0;

    int n_vec = 0;
    int n_miss = 0;

    typedef struct {
        logic        iv;
        logic [31:0] ia;
        logic        rdy;
        logic        bv;
        logic [31:0] bia;
        logic [31:0] ba;
        logic        e_ov;
        logic [31:0] e_oa;
        logic        e_full;
    } vec_t;

    vec_t vecs[$];

    cpu_instruction_queue #(.DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .in_address(in_address), .in_instruction(in_instruction), .in_valid(in_valid),
        .in_full(in_full),
        .out_address(out_address), .out_instruction(out_instruction), .out_adel(out_adel),
        .out_valid(out_valid), .out_ready(out_ready),
        .branch_valid(branch_valid), .branch_inst_addr(branch_inst_addr),
        .branch_address(branch_address)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [31:0] ia, input logic rdy, input logic bv,
                       input logic [31:0] bia, input logic [31:0] ba,
                       input logic e_ov, input logic [31:0] e_oa, input logic e_full);
        vec_t v;
        v.iv = iv; v.ia = ia; v.rdy = rdy; v.bv = bv; v.bia = bia; v.ba = ba;
        v.e_ov = e_ov; v.e_oa = e_oa; v.e_full = e_full;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic iv, input logic [31:0] ia, input logic rdy,
                         input logic bv, input logic [31:0] bia, input logic [31:0] ba);
        in_valid = iv; in_address = ia; in_instruction = ia ^ IMASK; out_ready = rdy;
        branch_valid = bv; branch_inst_addr = bia; branch_address = ba;
    endtask

    initial begin
        logic exp_adel;
        // fill, overflow drop, drain
        add(1, 32'hbfc00000, 0, 0, 0, 0, 1, 32'hbfc00000, 0);
        add(1, 32'hbfc00004, 0, 0, 0, 0, 1, 32'hbfc00000, 0);
        add(1, 32'hbfc00008, 0, 0, 0, 0, 1, 32'hbfc00000, 1);
        add(1, 32'hbfc0000c, 0, 0, 0, 0, 1, 32'hbfc00000, 1);
        add(1, 32'hbfc00010, 0, 0, 0, 0, 1, 32'hbfc00000, 1);
        add(0, 0, 1, 0, 0, 0, 1, 32'hbfc00004, 1);
        add(0, 0, 1, 0, 0, 0, 1, 32'hbfc00008, 0);
        add(0, 0, 1, 0, 0, 0, 1, 32'hbfc0000c, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);
        // steady push/pop at count=2
        add(1, 32'h10, 0, 0, 0, 0, 1, 32'h10, 0);
        add(1, 32'h14, 0, 0, 0, 0, 1, 32'h10, 0);
        for (int k = 1; k <= 10; k++)
            add(1, 32'h14 + 32'(4 * k), 1, 0, 0, 0, 1, 32'h10 + 32'(4 * k), 0);
        add(0, 0, 1, 0, 0, 0, 1, 32'h3c, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);
        // branch with slot already queued
        add(1, 32'h100, 0, 0, 0, 0, 1, 32'h100, 0);
        add(1, 32'h104, 0, 0, 0, 0, 1, 32'h100, 0);
        add(1, 32'h108, 0, 0, 0, 0, 1, 32'h100, 1);
        add(1, 32'h10c, 0, 0, 0, 0, 1, 32'h100, 1);
        add(0, 0, 0, 1, 32'h100, 32'h200, 1, 32'h104, 0);
        add(1, 32'h110, 0, 0, 0, 0, 1, 32'h104, 0);
        add(1, 32'h200, 0, 0, 0, 0, 1, 32'h104, 0);
        add(1, 32'h204, 0, 0, 0, 0, 1, 32'h104, 1);
        add(0, 0, 1, 0, 0, 0, 1, 32'h200, 0);
        add(0, 0, 1, 0, 0, 0, 1, 32'h204, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);
        // branch with slot not yet fetched
        add(0, 0, 0, 1, 32'h3fc, 32'h80, 0, 0, 0);
        add(1, 32'h3f8, 0, 0, 0, 0, 0, 0, 0);
        add(1, 32'h400, 0, 0, 0, 0, 1, 32'h400, 0);
        add(1, 32'h404, 0, 0, 0, 0, 1, 32'h400, 0);
        add(1, 32'h80, 0, 0, 0, 0, 1, 32'h400, 0);
        add(1, 32'h84, 0, 0, 0, 0, 1, 32'h400, 1);
        add(0, 0, 1, 0, 0, 0, 1, 32'h80, 0);
        add(0, 0, 1, 0, 0, 0, 1, 32'h84, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);
        // branch concurrent with pop of the branch and push of the slot
        add(1, 32'h100, 0, 0, 0, 0, 1, 32'h100, 0);
        add(1, 32'h104, 1, 1, 32'h100, 32'h300, 1, 32'h104, 0);
        add(1, 32'h108, 0, 0, 0, 0, 1, 32'h104, 0);
        add(1, 32'h300, 0, 0, 0, 0, 1, 32'h104, 0);
        add(0, 0, 1, 0, 0, 0, 1, 32'h300, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);

        repeat (2) @(negedge clock);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_in_full", 32'(in_full), 0);
        check("reset_out_address", out_address, 0);
        check("reset_out_instruction", out_instruction, 0);
        check("reset_out_adel", 32'(out_adel), 0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clock);
            drive(vecs[i].iv, vecs[i].ia, vecs[i].rdy, vecs[i].bv, vecs[i].bia, vecs[i].ba);
            @(posedge clock);
            #1;
            check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            check($sformatf("v%0d_in_full", i), 32'(in_full), 32'(vecs[i].e_full));
            if (vecs[i].e_ov) begin
                check($sformatf("v%0d_out_address", i), out_address, vecs[i].e_oa);
                check($sformatf("v%0d_out_instruction", i), out_instruction, vecs[i].e_oa ^ IMASK);
            end
        end

        // async reset in the middle of a fill
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            drive(1, 32'h500 + 32'(4 * k), 0, 0, 0, 0);
        end
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0);
        check("prefill_in_full", 32'(in_full), 1);
        #2 reset = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid), 0);
        check("async_in_full", 32'(in_full), 0);
        @(negedge clock);
        reset = 1'b1;
        drive(1, 32'h0, 0, 0, 0, 0);
        @(negedge clock);
        drive(1, 32'h2, 0, 0, 0, 0);
        @(negedge clock);
        drive(0, 0, 1, 0, 0, 0);
        check("adel_aligned_addr", out_address, 32'h0);
        check("adel_aligned", 32'(out_adel), 0);
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0);
`ifdef INSTQ_ALIGN_CHECK_EN
        exp_adel = 1'b1;
`else
        exp_adel = 1'b0;
`endif
        check("adel_misaligned_addr", out_address, 32'h2);
        check("adel_misaligned", 32'(out_adel), 32'(exp_adel));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
